// File: rtl/pipeline_pkg.sv
// Shared encodings for the miniRV pipeline hazard controller.
// Forward-select codes, controller states and the hard-wired zero register.
package pipeline_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EXE = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    // Youngest producer wins: EXE beats MEM beats WB.
    function automatic logic [1:0] fwd_pick(
        input logic exe_hit,
        input logic mem_hit,
        input logic wb_hit
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (exe_hit) begin
            sel = FWD_EXE;
        end else if (mem_hit) begin
            sel = FWD_MEM;
        end else if (wb_hit) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/raw_match.sv
// Per-source RAW comparator against the EXE/MEM/WB destinations.
// x0 and unused sources never produce a hit.
module raw_match
    import pipeline_pkg::*;
(
    input  logic       src_used_i,
    input  logic [4:0] src_i,
    input  logic [4:0] exe_rd_i,
    input  logic       exe_we_i,
    input  logic [4:0] mem_rd_i,
    input  logic       mem_we_i,
    input  logic [4:0] wb_rd_i,
    input  logic       wb_we_i,
    output logic       exe_hit_o,
    output logic       mem_hit_o,
    output logic       wb_hit_o
);

    logic live;

    assign live      = src_used_i && (src_i != REG_ZERO);
    assign exe_hit_o = live && exe_we_i && (exe_rd_i == src_i);
    assign mem_hit_o = live && mem_we_i && (mem_rd_i == src_i);
    assign wb_hit_o  = live && wb_we_i  && (wb_rd_i  == src_i);

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage miniRV pipeline.
// Memory freeze > branch flush > load-use / RAW stall; forwarding is zero-latency.
module pipeline_ctrl
    import pipeline_pkg::*;
#(
    parameter int FWD_EN      = 1,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [4:0]       exe_rd,
    input  logic [4:0]       mem_rd,
    input  logic [4:0]       wb_rd,
    input  logic             exe_we,
    input  logic             mem_we,
    input  logic             wb_we,
    input  logic             exe_is_load,
    input  logic             exe_br_taken,
    input  logic             dmem_req,
    input  logic             dmem_ack,
    output logic             stop_PC,
    output logic             stop_IF_ID,
    output logic             stop_ID_EXE,
    output logic             stop_EXE_MEM,
    output logic             flush_IF_ID,
    output logic             flush_ID_EXE,
    output logic             flush_MEM_WB,
    output logic [1:0]       fwd_rs1_sel,
    output logic [1:0]       fwd_rs2_sel,
    output logic             err_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic       FWD_ON  = (FWD_EN != 0);
    localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

    state_t           state_q, state_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic rs1_exe, rs1_mem, rs1_wb;
    logic rs2_exe, rs2_mem, rs2_wb;
    logic mem_busy, br_flush, load_use, any_hit, id_stall, any_stop;

    raw_match u_rs1 (
        .src_used_i (id_rs1_used),
        .src_i      (id_rs1),
        .exe_rd_i   (exe_rd),
        .exe_we_i   (exe_we),
        .mem_rd_i   (mem_rd),
        .mem_we_i   (mem_we),
        .wb_rd_i    (wb_rd),
        .wb_we_i    (wb_we),
        .exe_hit_o  (rs1_exe),
        .mem_hit_o  (rs1_mem),
        .wb_hit_o   (rs1_wb)
    );

    raw_match u_rs2 (
        .src_used_i (id_rs2_used),
        .src_i      (id_rs2),
        .exe_rd_i   (exe_rd),
        .exe_we_i   (exe_we),
        .mem_rd_i   (mem_rd),
        .mem_we_i   (mem_we),
        .wb_rd_i    (wb_rd),
        .wb_we_i    (wb_we),
        .exe_hit_o  (rs2_exe),
        .mem_hit_o  (rs2_mem),
        .wb_hit_o   (rs2_wb)
    );

    // The ack cycle is already free; a fresh req without ack freezes at once.
    assign mem_busy = ((state_q == MEM_WAIT) || dmem_req) && !dmem_ack;
    assign br_flush = rst_n && !mem_busy && exe_br_taken;
    assign load_use = exe_is_load && (rs1_exe || rs2_exe);
    assign any_hit  = rs1_exe || rs1_mem || rs1_wb
                   || rs2_exe || rs2_mem || rs2_wb;
    assign id_stall = FWD_ON ? load_use : any_hit;
    assign any_stop = stop_PC || stop_IF_ID || stop_ID_EXE || stop_EXE_MEM;

    // Priority-resolved stop/flush/forward outputs.
    always_comb begin
        stop_PC      = 1'b0;
        stop_IF_ID   = 1'b0;
        stop_ID_EXE  = 1'b0;
        stop_EXE_MEM = 1'b0;
        flush_IF_ID  = 1'b0;
        flush_ID_EXE = 1'b0;
        flush_MEM_WB = 1'b0;
        fwd_rs1_sel  = FWD_RF;
        fwd_rs2_sel  = FWD_RF;
        if (!rst_n) begin
            flush_IF_ID  = 1'b1;
            flush_ID_EXE = 1'b1;
            flush_MEM_WB = 1'b1;
        end else begin
            if (FWD_ON) begin
                fwd_rs1_sel = fwd_pick(rs1_exe, rs1_mem, rs1_wb);
                fwd_rs2_sel = fwd_pick(rs2_exe, rs2_mem, rs2_wb);
            end
            if (mem_busy) begin
                stop_PC      = 1'b1;
                stop_IF_ID   = 1'b1;
                stop_ID_EXE  = 1'b1;
                stop_EXE_MEM = 1'b1;
                flush_MEM_WB = 1'b1;
            end else if (exe_br_taken) begin
                flush_IF_ID  = 1'b1;
                flush_ID_EXE = 1'b1;
            end else if (id_stall) begin
                stop_PC      = 1'b1;
                stop_IF_ID   = 1'b1;
                flush_ID_EXE = 1'b1;
            end
        end
    end

    // Next state, saturating wait timer, sticky error and counters.
    always_comb begin
        state_d     = mem_busy ? MEM_WAIT : RUN;
        wait_cnt_d  = 8'd0;
        if (mem_busy) begin
            wait_cnt_d = (wait_cnt_q >= TIMEOUT) ? TIMEOUT
                                                 : wait_cnt_q + 8'd1;
        end
        err_d       = err_q || (mem_busy && (wait_cnt_d == TIMEOUT));
        stall_cnt_d = stall_cnt_q + CNT_W'(any_stop);
        flush_cnt_d = flush_cnt_q + CNT_W'(br_flush);
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= RUN;
            wait_cnt_q  <= 8'd0;
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            err_q       <= err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign err_timeout = err_q;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: instance A forwards (timeout 4), instance B stalls.
// Table vectors, directed multi-cycle sequences, then random traffic vs a model.
module tb_pipeline_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [4:0] id_rs1, id_rs2, exe_rd, mem_rd, wb_rd;
    logic       id_rs1_used, id_rs2_used;
    logic       exe_we, mem_we, wb_we;
    logic       exe_is_load, exe_br_taken, dmem_req, dmem_ack;

    logic        a_spc, a_sif, a_sid, a_sem, a_fif, a_fid, a_fmw, a_err;
    logic [1:0]  a_s1, a_s2;
    logic [31:0] a_stc, a_flc;
    logic        b_spc, b_sif, b_sid, b_sem, b_fif, b_fid, b_fmw, b_err;
    logic [1:0]  b_s1, b_s2;
    logic [31:0] b_stc, b_flc;

    pipeline_ctrl #(.FWD_EN(1), .MEM_TIMEOUT(4), .CNT_W(32)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .exe_rd(exe_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .exe_we(exe_we), .mem_we(mem_we), .wb_we(wb_we),
        .exe_is_load(exe_is_load), .exe_br_taken(exe_br_taken),
        .dmem_req(dmem_req), .dmem_ack(dmem_ack),
        .stop_PC(a_spc), .stop_IF_ID(a_sif),
        .stop_ID_EXE(a_sid), .stop_EXE_MEM(a_sem),
        .flush_IF_ID(a_fif), .flush_ID_EXE(a_fid), .flush_MEM_WB(a_fmw),
        .fwd_rs1_sel(a_s1), .fwd_rs2_sel(a_s2),
        .err_timeout(a_err), .stall_cnt(a_stc), .flush_cnt(a_flc)
    );

    pipeline_ctrl #(.FWD_EN(0), .MEM_TIMEOUT(255), .CNT_W(32)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .exe_rd(exe_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .exe_we(exe_we), .mem_we(mem_we), .wb_we(wb_we),
        .exe_is_load(exe_is_load), .exe_br_taken(exe_br_taken),
        .dmem_req(dmem_req), .dmem_ack(dmem_ack),
        .stop_PC(b_spc), .stop_IF_ID(b_sif),
        .stop_ID_EXE(b_sid), .stop_EXE_MEM(b_sem),
        .flush_IF_ID(b_fif), .flush_ID_EXE(b_fid), .flush_MEM_WB(b_fmw),
        .fwd_rs1_sel(b_s1), .fwd_rs2_sel(b_s2),
        .err_timeout(b_err), .stall_cnt(b_stc), .flush_cnt(b_flc)
    );

    logic [3:0]  act_stop  [2];
    logic [2:0]  act_flush [2];
    logic [1:0]  act_s1    [2];
    logic [1:0]  act_s2    [2];
    logic        act_err   [2];
    logic [31:0] act_stc   [2];
    logic [31:0] act_flc   [2];

    assign act_stop[0]  = {a_spc, a_sif, a_sid, a_sem};
    assign act_stop[1]  = {b_spc, b_sif, b_sid, b_sem};
    assign act_flush[0] = {a_fif, a_fid, a_fmw};
    assign act_flush[1] = {b_fif, b_fid, b_fmw};
    assign act_s1[0]    = a_s1;
    assign act_s1[1]    = b_s1;
    assign act_s2[0]    = a_s2;
    assign act_s2[1]    = b_s2;
    assign act_err[0]   = a_err;
    assign act_err[1]   = b_err;
    assign act_stc[0]   = a_stc;
    assign act_stc[1]   = b_stc;
    assign act_flc[0]   = a_flc;
    assign act_flc[1]   = b_flc;

    int checks = 0;
    int errors = 0;

    // Reference model state, one slot per instance.
    int          cfg_to  [2] = '{4, 255};
    bit          cfg_fwd [2] = '{1'b1, 1'b0};
    bit          m_wait  [2];
    int          m_waits [2];
    bit          m_err   [2];
    logic [31:0] m_stc   [2];
    logic [31:0] m_flc   [2];

    logic [3:0]  e_stop  [2];
    logic [2:0]  e_flush [2];
    logic [1:0]  e_s1    [2];
    logic [1:0]  e_s2    [2];
    bit          e_busy  [2];
    bit          e_br    [2];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    // 0 = no producer, 1 = EXE, 2 = MEM, 3 = WB; youngest first.
    function automatic logic [1:0] youngest(input logic used,
                                            input logic [4:0] src);
        logic [4:0] rd [3];
        logic       we [3];
        rd[0] = exe_rd; rd[1] = mem_rd; rd[2] = wb_rd;
        we[0] = exe_we; we[1] = mem_we; we[2] = wb_we;
        for (int s = 0; s < 3; s++) begin
            if (used && src != 5'd0 && we[s] && rd[s] == src) begin
                return 2'(s + 1);
            end
        end
        return 2'd0;
    endfunction

    task automatic model_eval();
        logic [1:0] h1, h2;
        bit hz;
        h1 = youngest(id_rs1_used, id_rs1);
        h2 = youngest(id_rs2_used, id_rs2);
        for (int k = 0; k < 2; k++) begin
            e_stop[k]  = 4'b0000;
            e_flush[k] = 3'b000;
            e_s1[k]    = cfg_fwd[k] ? h1 : 2'b00;
            e_s2[k]    = cfg_fwd[k] ? h2 : 2'b00;
            e_busy[k]  = (m_wait[k] || dmem_req) && !dmem_ack;
            e_br[k]    = 1'b0;
            if (cfg_fwd[k]) hz = exe_is_load && (h1 == 2'd1 || h2 == 2'd1);
            else            hz = (h1 != 2'd0) || (h2 != 2'd0);
            if (!rst_n) begin
                e_flush[k] = 3'b111;
                e_s1[k]    = 2'b00;
                e_s2[k]    = 2'b00;
                e_busy[k]  = 1'b0;
            end else if (e_busy[k]) begin
                e_stop[k]  = 4'b1111;
                e_flush[k] = 3'b001;
            end else if (exe_br_taken) begin
                e_flush[k] = 3'b110;
                e_br[k]    = 1'b1;
            end else if (hz) begin
                e_stop[k]  = 4'b1100;
                e_flush[k] = 3'b010;
            end
        end
    endtask

    task automatic model_update();
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_wait[k] = 1'b0; m_waits[k] = 0; m_err[k] = 1'b0;
                m_stc[k] = 32'd0; m_flc[k] = 32'd0;
            end else begin
                m_stc[k] = m_stc[k] + ((e_stop[k] != 4'b0) ? 32'd1 : 32'd0);
                m_flc[k] = m_flc[k] + (e_br[k] ? 32'd1 : 32'd0);
                if (e_busy[k]) begin
                    if (m_waits[k] < cfg_to[k]) m_waits[k]++;
                    if (m_waits[k] == cfg_to[k]) m_err[k] = 1'b1;
                end else begin
                    m_waits[k] = 0;
                end
                m_wait[k] = e_busy[k];
            end
        end
    endtask

    // Inputs are driven at negedge; outputs sampled 2 time units later.
    task automatic settle();
        string p;
        #2;
        model_eval();
        for (int k = 0; k < 2; k++) begin
            p = (k == 0) ? "A" : "B";
            chk({p, " stop"},      32'(act_stop[k]),  32'(e_stop[k]));
            chk({p, " flush"},     32'(act_flush[k]), 32'(e_flush[k]));
            chk({p, " rs1_sel"},   32'(act_s1[k]),    32'(e_s1[k]));
            chk({p, " rs2_sel"},   32'(act_s2[k]),    32'(e_s2[k]));
            chk({p, " err"},       32'(act_err[k]),   32'(m_err[k]));
            chk({p, " stall_cnt"}, act_stc[k],        m_stc[k]);
            chk({p, " flush_cnt"}, act_flc[k],        m_flc[k]);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        model_update();
        @(negedge clk);
    endtask

    task automatic idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
        exe_rd = 5'd0; mem_rd = 5'd0; wb_rd = 5'd0;
        exe_we = 1'b0; mem_we = 1'b0; wb_we = 1'b0;
        exe_is_load = 1'b0; exe_br_taken = 1'b0;
        dmem_req = 1'b0; dmem_ack = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        settle();
        adv();
        settle();
        chk("rst flush", 32'(act_flush[0]), 32'h7);
        chk("rst stop",  32'(act_stop[0]),  32'h0);
        chk("rst sel",   32'({a_s1, a_s2}), 32'h0);
        adv();
        rst_n = 1'b1;
        settle();
        chk("rel stall_cnt", a_stc, 32'd0);
        chk("rel err",       32'(a_err), 32'd0);
    endtask

    task automatic load_use_in(input logic br);
        idle();
        id_rs2 = 5'd7; id_rs2_used = 1'b1;
        exe_rd = 5'd7; exe_we = 1'b1; exe_is_load = 1'b1;
        exe_br_taken = br;
    endtask

    typedef struct {
        logic [4:0] rs1; logic u1; logic [4:0] rs2; logic u2;
        logic [4:0] erd; logic ewe; logic [4:0] mrd; logic mwe;
        logic [4:0] wrd; logic wwe;
        logic ld; logic br; logic req; logic ack;
        logic [3:0] stop; logic [2:0] flush;
        logic [1:0] s1; logic [1:0] s2; logic [3:0] stop_b;
    } vec_t;

    vec_t tbl [14];

    initial begin
        tbl[0]  = '{5'd5,1'b1,5'd0,1'b0, 5'd5,1'b1,5'd5,1'b1,5'd0,1'b0,
                    1'b0,1'b0,1'b0,1'b0, 4'b0000,3'b000,2'b01,2'b00,4'b1100};
        tbl[1]  = '{5'd0,1'b1,5'd0,1'b0, 5'd5,1'b1,5'd5,1'b1,5'd0,1'b0,
                    1'b0,1'b0,1'b0,1'b0, 4'b0000,3'b000,2'b00,2'b00,4'b0000};
        tbl[2]  = '{5'd0,1'b0,5'd9,1'b1, 5'd0,1'b0,5'd9,1'b1,5'd9,1'b1,
                    1'b0,1'b0,1'b0,1'b0, 4'b0000,3'b000,2'b00,2'b10,4'b1100};
        tbl[3]  = '{5'd3,1'b1,5'd0,1'b0, 5'd0,1'b0,5'd0,1'b0,5'd3,1'b1,
                    1'b0,1'b0,1'b0,1'b0, 4'b0000,3'b000,2'b11,2'b00,4'b1100};
        tbl[4]  = '{5'd3,1'b0,5'd0,1'b0, 5'd0,1'b0,5'd0,1'b0,5'd3,1'b1,
                    1'b0,1'b0,1'b0,1'b0, 4'b0000,3'b000,2'b00,2'b00,4'b0000};
        tbl[5]  = '{5'd4,1'b1,5'd0,1'b0, 5'd4,1'b0,5'd4,1'b1,5'd0,1'b0,
                    1'b0,1'b0,1'b0,1'b0, 4'b0000,3'b000,2'b10,2'b00,4'b1100};
        tbl[6]  = '{5'd8,1'b1,5'd8,1'b1, 5'd8,1'b1,5'd0,1'b0,5'd8,1'b1,
                    1'b0,1'b0,1'b0,1'b0, 4'b0000,3'b000,2'b01,2'b01,4'b1100};
        tbl[7]  = '{5'd0,1'b0,5'd7,1'b1, 5'd7,1'b1,5'd0,1'b0,5'd0,1'b0,
                    1'b1,1'b0,1'b0,1'b0, 4'b1100,3'b010,2'b00,2'b01,4'b1100};
        tbl[8]  = '{5'd0,1'b0,5'd7,1'b1, 5'd7,1'b1,5'd0,1'b0,5'd0,1'b0,
                    1'b1,1'b1,1'b0,1'b0, 4'b0000,3'b110,2'b00,2'b01,4'b0000};
        tbl[9]  = '{5'd0,1'b1,5'd0,1'b0, 5'd0,1'b1,5'd0,1'b0,5'd0,1'b0,
                    1'b1,1'b0,1'b0,1'b0, 4'b0000,3'b000,2'b00,2'b00,4'b0000};
        tbl[10] = '{5'd2,1'b1,5'd0,1'b0, 5'd0,1'b0,5'd2,1'b1,5'd0,1'b0,
                    1'b0,1'b0,1'b1,1'b1, 4'b0000,3'b000,2'b10,2'b00,4'b1100};
        tbl[11] = '{5'd6,1'b1,5'd0,1'b0, 5'd6,1'b1,5'd6,1'b1,5'd0,1'b0,
                    1'b1,1'b0,1'b0,1'b0, 4'b1100,3'b010,2'b01,2'b00,4'b1100};
        tbl[12] = '{5'd6,1'b0,5'd0,1'b0, 5'd6,1'b1,5'd0,1'b0,5'd0,1'b0,
                    1'b1,1'b0,1'b0,1'b0, 4'b0000,3'b000,2'b00,2'b00,4'b0000};
        tbl[13] = '{5'd6,1'b1,5'd0,1'b0, 5'd6,1'b0,5'd0,1'b0,5'd0,1'b0,
                    1'b1,1'b0,1'b0,1'b0, 4'b0000,3'b000,2'b00,2'b00,4'b0000};

        rst_n = 1'b0;
        idle();
        for (int k = 0; k < 2; k++) begin
            e_stop[k] = 4'b0; e_flush[k] = 3'b0; e_s1[k] = 2'b0; e_s2[k] = 2'b0;
            e_busy[k] = 1'b0; e_br[k] = 1'b0;
        end
        @(posedge clk);
        #1;
        model_update();
        @(negedge clk);

        do_reset();
        adv();

        // Single-cycle vectors from RUN.
        for (int i = 0; i < 14; i++) begin
            idle();
            id_rs1 = tbl[i].rs1; id_rs1_used = tbl[i].u1;
            id_rs2 = tbl[i].rs2; id_rs2_used = tbl[i].u2;
            exe_rd = tbl[i].erd; exe_we = tbl[i].ewe;
            mem_rd = tbl[i].mrd; mem_we = tbl[i].mwe;
            wb_rd  = tbl[i].wrd; wb_we  = tbl[i].wwe;
            exe_is_load = tbl[i].ld; exe_br_taken = tbl[i].br;
            dmem_req = tbl[i].req; dmem_ack = tbl[i].ack;
            settle();
            chk($sformatf("vec%0d A stop", i),  32'(act_stop[0]),  32'(tbl[i].stop));
            chk($sformatf("vec%0d A flush", i), 32'(act_flush[0]), 32'(tbl[i].flush));
            chk($sformatf("vec%0d A rs1", i),   32'(a_s1),         32'(tbl[i].s1));
            chk($sformatf("vec%0d A rs2", i),   32'(a_s2),         32'(tbl[i].s2));
            chk($sformatf("vec%0d B stop", i),  32'(act_stop[1]),  32'(tbl[i].stop_b));
            adv();
        end

        // Load-use bubble, then MEM forwarding.
        do_reset();
        adv();
        load_use_in(1'b0);
        settle();
        chk("lu stop",  32'(act_stop[0]),  32'b1100);
        chk("lu flush", 32'(act_flush[0]), 32'b010);
        adv();
        idle();
        id_rs2 = 5'd7; id_rs2_used = 1'b1; mem_rd = 5'd7; mem_we = 1'b1;
        settle();
        chk("lu2 stop",      32'(act_stop[0]), 32'b0000);
        chk("lu2 rs2",       32'(a_s2),        32'b10);
        chk("lu2 stall_cnt", a_stc,            32'd1);
        adv();

        // Branch overrides load-use.
        do_reset();
        adv();
        load_use_in(1'b1);
        settle();
        chk("br stop",  32'(act_stop[0]),  32'b0000);
        chk("br flush", 32'(act_flush[0]), 32'b110);
        adv();
        idle();
        settle();
        chk("br flush_cnt", a_flc, 32'd1);
        chk("br stall_cnt", a_stc, 32'd0);
        adv();

        // Three-cycle memory wait; branches during the freeze are ignored.
        do_reset();
        adv();
        for (int c = 0; c < 3; c++) begin
            idle();
            dmem_req = 1'b1; exe_br_taken = 1'b1;
            settle();
            chk($sformatf("mw%0d stop", c),  32'(act_stop[0]),  32'hF);
            chk($sformatf("mw%0d flush", c), 32'(act_flush[0]), 32'b001);
            adv();
        end
        idle();
        dmem_req = 1'b1; dmem_ack = 1'b1;
        settle();
        chk("mw ack stop", 32'(act_stop[0]), 32'h0);
        adv();
        idle();
        settle();
        chk("mw stall_cnt", a_stc, 32'd3);
        chk("mw flush_cnt", a_flc, 32'd0);
        adv();

        // Timeout: ack withheld for 10 cycles.
        do_reset();
        adv();
        for (int c = 1; c <= 10; c++) begin
            idle();
            dmem_req = 1'b1;
            settle();
            chk($sformatf("to%0d A err", c), 32'(a_err), (c >= 5) ? 32'd1 : 32'd0);
            chk($sformatf("to%0d B err", c), 32'(b_err), 32'd0);
            adv();
        end
        dmem_ack = 1'b1;
        settle();
        chk("to ack err",  32'(a_err),       32'd1);
        chk("to ack stop", 32'(act_stop[0]), 32'h0);
        adv();
        idle();
        settle();
        chk("to after err", 32'(a_err), 32'd1);
        adv();

        // No-forwarding instance: WB hit, then a producer walking EXE->MEM->WB.
        do_reset();
        adv();
        idle();
        id_rs1 = 5'd3; id_rs1_used = 1'b1; wb_rd = 5'd3; wb_we = 1'b1;
        settle();
        chk("nf wb B stop", 32'(act_stop[1]), 32'b1100);
        chk("nf wb B sel",  32'(b_s1),        32'b00);
        chk("nf wb A sel",  32'(a_s1),        32'b11);
        adv();
        idle();
        settle();
        chk("nf idle B stop", 32'(act_stop[1]), 32'b0000);
        adv();
        for (int c = 0; c < 4; c++) begin
            idle();
            id_rs1 = 5'd6; id_rs1_used = 1'b1;
            if (c == 0) begin exe_rd = 5'd6; exe_we = 1'b1; end
            if (c == 1) begin mem_rd = 5'd6; mem_we = 1'b1; end
            if (c == 2) begin wb_rd  = 5'd6; wb_we  = 1'b1; end
            settle();
            chk($sformatf("nf walk%0d B stop", c), 32'(act_stop[1]),
                (c < 3) ? 32'hC : 32'h0);
            adv();
        end
        settle();
        chk("nf B stall_cnt", b_stc, 32'd4);
        adv();

        // Random traffic against the model.
        do_reset();
        adv();
        for (int n = 0; n < 3000; n++) begin
            rst_n        = ($urandom_range(0, 149) != 0);
            id_rs1       = 5'($urandom_range(0, 3));
            id_rs2       = 5'($urandom_range(0, 3));
            id_rs1_used  = 1'($urandom_range(0, 3) != 0);
            id_rs2_used  = 1'($urandom_range(0, 1));
            exe_rd       = 5'($urandom_range(0, 3));
            mem_rd       = 5'($urandom_range(0, 3));
            wb_rd        = 5'($urandom_range(0, 3));
            exe_we       = 1'($urandom_range(0, 1));
            mem_we       = 1'($urandom_range(0, 1));
            wb_we        = 1'($urandom_range(0, 1));
            exe_is_load  = 1'($urandom_range(0, 3) == 0);
            exe_br_taken = 1'($urandom_range(0, 7) == 0);
            dmem_req     = 1'($urandom_range(0, 2) == 0);
            dmem_ack     = 1'($urandom_range(0, 2) == 0);
            settle();
            adv();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
